// File: rtl/sonic_multi_ranger.sv
// Round-robin trigger/echo controller for several HC-SR04-class sensors.
// One sensor is pinged at a time; echo width is converted to whole centimetres.
module sonic_multi_ranger #(
    parameter int CHANNELS    = 2,
    parameter int DIST_W      = 10,
    parameter int TRIG_CYC    = 1000,
    parameter int CM_CYC      = 5800,
    parameter int TIMEOUT_CYC = 3000000,
    parameter int GAP_CYC     = 1000000,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [CHANNELS-1:0]          echo,
    output logic [CHANNELS-1:0]          trig,
    output logic [CHANNELS*DIST_W-1:0]   distance,
    output logic [CHANNELS-1:0]          valid,
    output logic [CHANNELS-1:0]          timeout,
    output logic                         done,
    output logic [CH_W-1:0]              done_ch
);

    localparam int CNT_MAX = (TRIG_CYC > GAP_CYC) ? TRIG_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int SUB_W   = $clog2(CM_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GAP
    } state_t;

    state_t                            state_q, state_d;
    logic [CH_W-1:0]                   ch_q, ch_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [TO_W-1:0]                   to_q, to_d;
    logic [SUB_W-1:0]                  sub_q, sub_d;
    logic [DIST_W-1:0]                 cm_q, cm_d;
    logic [CHANNELS-1:0][DIST_W-1:0]   dist_q, dist_d;
    logic [CHANNELS-1:0]               valid_q, valid_d;
    logic [CHANNELS-1:0]               timeout_q, timeout_d;
    logic [CHANNELS-1:0]               trig_q, trig_d;
    logic                              done_q, done_d;
    logic [CH_W-1:0]                   done_ch_q, done_ch_d;
    logic [CHANNELS-1:0]               echo_s1_q, echo_s1_d;
    logic [CHANNELS-1:0]               echo_s2_q, echo_s2_d;
    logic [CHANNELS-1:0]               echo_dly_q, echo_dly_d;

    logic echo_s;
    logic rise;
    logic fall;
    logic to_hit;
    logic wr_good;
    logic wr_to;

    always_comb begin
        echo_s1_d  = echo;
        echo_s2_d  = echo_s1_q;
        echo_dly_d = echo_s2_q;
        echo_s     = echo_s2_q[ch_q];
        rise       = echo_s & ~echo_dly_q[ch_q];
        fall       = ~echo_s & echo_dly_q[ch_q];
        to_hit     = (to_q == TO_W'(TIMEOUT_CYC - 1));
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        sub_d     = sub_q;
        cm_d      = cm_q;
        dist_d    = dist_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;
        done_ch_d = done_ch_q;
        trig_d    = '0;
        wr_good   = 1'b0;
        wr_to     = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                to_d  = '0;
                if (en) begin
                    ch_d    = '0;
                    state_d = TRIG;
                end
            end
            TRIG: begin
                to_d = '0;
                if (cnt_q == CNT_W'(TRIG_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = WAIT_RISE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_RISE: begin
                to_d = to_q + TO_W'(1);
                if (to_hit) begin
                    wr_to = 1'b1;
                end else if (rise) begin
                    // the cycle that shows the edge is already high time
                    sub_d   = (CM_CYC == 1) ? SUB_W'(0) : SUB_W'(1);
                    cm_d    = (CM_CYC == 1) ? DIST_W'(1) : DIST_W'(0);
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                to_d = to_q + TO_W'(1);
                if (fall) begin
                    wr_good = 1'b1;
                end else if (to_hit) begin
                    wr_to = 1'b1;
                end else if (echo_s) begin
                    if (sub_q == SUB_W'(CM_CYC - 1)) begin
                        sub_d = '0;
                        if (cm_q != '1) begin
                            cm_d = cm_q + DIST_W'(1);
                        end
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    cnt_d = '0;
                    if (en) begin
                        ch_d    = (ch_q == CH_W'(CHANNELS - 1)) ? '0
                                                                : ch_q + CH_W'(1);
                        state_d = TRIG;
                    end else begin
                        ch_d    = '0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_good || wr_to) begin
            dist_d[ch_q]    = wr_to ? '1 : cm_q;
            valid_d[ch_q]   = wr_good;
            timeout_d[ch_q] = wr_to;
            done_d          = 1'b1;
            done_ch_d       = ch_q;
            cnt_d           = '0;
            state_d         = GAP;
        end

        if (state_d == TRIG) begin
            trig_d[ch_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            cnt_q      <= '0;
            to_q       <= '0;
            sub_q      <= '0;
            cm_q       <= '0;
            dist_q     <= '0;
            valid_q    <= '0;
            timeout_q  <= '0;
            trig_q     <= '0;
            done_q     <= 1'b0;
            done_ch_q  <= '0;
            echo_s1_q  <= '0;
            echo_s2_q  <= '0;
            echo_dly_q <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            sub_q      <= sub_d;
            cm_q       <= cm_d;
            dist_q     <= dist_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            trig_q     <= trig_d;
            done_q     <= done_d;
            done_ch_q  <= done_ch_d;
            echo_s1_q  <= echo_s1_d;
            echo_s2_q  <= echo_s2_d;
            echo_dly_q <= echo_dly_d;
        end
    end

    assign trig     = trig_q;
    assign distance = dist_q;
    assign valid    = valid_q;
    assign timeout  = timeout_q;
    assign done     = done_q;
    assign done_ch  = done_ch_q;

endmodule

// File: tb/tb_sonic_multi_ranger.sv
// Directed bench for sonic_multi_ranger: 6-bit and 4-bit distance instances
// driven by the same enable/echo stimulus.
module tb_sonic_multi_ranger;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  echo;
    logic [1:0]  trig;
    logic [11:0] distance;
    logic [1:0]  valid;
    logic [1:0]  timeout;
    logic        done;
    logic        done_ch;
    logic [1:0]  trig4;
    logic [7:0]  distance4;
    logic [1:0]  valid4;
    logic [1:0]  timeout4;
    logic        done4;
    logic        done_ch4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_seen = 0;
    int w, t0, d0, n, nd;

    sonic_multi_ranger #(
        .CHANNELS(2), .DIST_W(6), .TRIG_CYC(4), .CM_CYC(10),
        .TIMEOUT_CYC(200), .GAP_CYC(20)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .echo(echo), .trig(trig),
        .distance(distance), .valid(valid), .timeout(timeout),
        .done(done), .done_ch(done_ch)
    );

    sonic_multi_ranger #(
        .CHANNELS(2), .DIST_W(4), .TRIG_CYC(4), .CM_CYC(10),
        .TIMEOUT_CYC(200), .GAP_CYC(20)
    ) dut_sat (
        .clk(clk), .rst(rst), .en(en), .echo(echo), .trig(trig4),
        .distance(distance4), .valid(valid4), .timeout(timeout4),
        .done(done4), .done_ch(done_ch4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_seen <= done_seen + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_trig(input logic [1:0] val, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (trig == val) return;
            @(negedge clk);
        end
        check("wait_trig", {30'd0, trig}, {30'd0, val});
    endtask

    task automatic trig_width(output int wd);
        logic [1:0] t;
        t  = trig;
        wd = 0;
        while (trig == t && t != 2'b00 && wd < 100) begin
            wd++;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (done) return;
            @(negedge clk);
        end
        check("wait_done", {31'd0, done}, 1);
    endtask

    task automatic pulse(input int c, input int len);
        echo[c] = 1'b1;
        repeat (len) @(negedge clk);
        echo[c] = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        echo = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_trig", trig, 0);
        check("rst_dist", distance, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_done", done, 0);
        check("rst_done_ch", done_ch, 0);
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;

        wait_trig(2'b01, 10);
        trig_width(w);
        check("trig0_width", w, 4);
        pulse(0, 125);
        wait_done(300);
        check("basic_done_ch", done_ch, 0);
        check("basic_dist0", distance[5:0], 12);
        check("basic_valid", valid, 2'b01);
        check("basic_timeout", timeout, 0);
        check("basic_dist1", distance[11:6], 0);
        d0 = cyc;
        @(negedge clk);
        check("done_one_cycle", done, 0);

        wait_trig(2'b10, 50);
        check("gap_len", cyc - d0, 20);
        check("trig1_only", trig, 2'b10);
        trig_width(w);
        check("trig1_width", w, 4);
        pulse(1, 190);
        wait_done(300);
        check("sat_done_ch", done_ch, 1);
        check("sat_dist1_w4", distance4[7:4], 15);
        check("sat_valid1_w4", valid4[1], 1);
        check("sat_dist1_w6", distance[11:6], 19);
        check("sat_dist0_kept", distance[5:0], 12);

        wait_trig(2'b01, 50);
        trig_width(w);
        t0 = cyc;
        wait_done(300);
        check("to_latency", cyc - t0, 200);
        check("to_dist0", distance[5:0], 63);
        check("to_valid0", valid[0], 0);
        check("to_flag0", timeout[0], 1);
        check("to_dist0_w4", distance4[3:0], 15);
        check("to_dist1_kept", distance[11:6], 19);

        wait_trig(2'b10, 50);
        trig_width(w);
        pulse(1, 57);
        wait_done(300);
        check("ch1_57_dist", distance[11:6], 5);

        wait_trig(2'b01, 50);
        trig_width(w);
        echo[0] = 1'b1;
        repeat (20) @(negedge clk);
        pulse(1, 30);
        repeat (33) @(negedge clk);
        echo[0] = 1'b0;
        wait_done(300);
        check("xtalk_dist0", distance[5:0], 8);
        check("xtalk_valid0", valid[0], 1);
        check("xtalk_to_clear", timeout[0], 0);
        check("xtalk_dist1", distance[11:6], 5);

        wait_trig(2'b10, 50);
        trig_width(w);
        pulse(1, 45);
        wait_done(300);
        check("ch1_45_dist", distance[11:6], 4);
        echo[0] = 1'b1;

        wait_trig(2'b01, 50);
        trig_width(w);
        wait_done(300);
        check("stuck_timeout", timeout[0], 1);
        check("stuck_dist0", distance[5:0], 63);
        check("stuck_valid0", valid[0], 0);
        echo[0] = 1'b0;

        wait_trig(2'b10, 50);
        trig_width(w);
        echo[1] = 1'b1;
        repeat (10) @(negedge clk);
        en = 1'b0;
        repeat (23) @(negedge clk);
        echo[1] = 1'b0;
        wait_done(300);
        check("endrop_dist1", distance[11:6], 3);
        check("endrop_valid1", valid[1], 1);
        check("endrop_done_ch", done_ch, 1);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (trig != 2'b00) n++;
        end
        check("idle_trig_quiet", n, 0);
        en = 1'b1;
        @(negedge clk);
        check("restart_ch0", trig, 2'b01);

        trig_width(w);
        echo[0] = 1'b1;
        repeat (20) @(negedge clk);
        nd = done_seen;
        rst = 1'b1;
        #1;
        check("rstm_trig", trig, 0);
        check("rstm_done", done, 0);
        check("rstm_dist", distance, 0);
        check("rstm_valid", valid, 0);
        check("rstm_timeout", timeout, 0);
        en   = 1'b0;
        echo = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rstm_no_done", done_seen, nd);
        check("rstm_idle_trig", trig, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got 0 expected 1");
        $fatal(1);
    end

endmodule
